// File: rtl/axi4lite_interconnect_param.sv
// ---------------------------------------------------------------------------
// axi4lite_interconnect_param
//
// Parametrised 1-to-N AXI4-lite interconnect. One upstream slave port fans
// out to NUM_SLAVES downstream master ports using a base + equal-size region
// address map. Read and write paths are independent FSMs with one
// outstanding transaction each, and they may target the same slot at once.
//
// Added behaviour relative to the fixed 16-port block:
//   - unmapped addresses complete locally with DECERR (2'b11)
//   - a per-transaction timeout completes with SLVERR (2'b10)
//   - upstream responses are presented from registers
//
// Ports:
//   s_axi_aclk, s_axi_areset    clock (rising edge), async active-low reset
//   s_axi_ar* / s_axi_r*        upstream read address / read data channels
//   s_axi_aw* / s_axi_w*        upstream write address / write data channels
//   s_axi_b*                    upstream write response channel
//   m_axi_*                     downstream channels, flattened per port:
//                               slice i of every vector belongs to port i.
//                               Address/data slices are driven to every
//                               port; only the selected port's valid/ready
//                               bit ever rises.
// ---------------------------------------------------------------------------
module axi4lite_interconnect_param #(
    parameter int unsigned           NUM_SLAVES     = 16,
    parameter int unsigned           ADDR_W         = 32,
    parameter int unsigned           DATA_W         = 32,
    parameter logic [ADDR_W-1:0]     BASE_ADDR      = '0,
    parameter int unsigned           REGION_LOG2    = 6,
    parameter int unsigned           TIMEOUT_CYCLES = 256
) (
    input  logic                           s_axi_aclk,
    input  logic                           s_axi_areset,

    input  logic [ADDR_W-1:0]              s_axi_araddr,
    input  logic                           s_axi_arvalid,
    output logic                           s_axi_arready,
    output logic [DATA_W-1:0]              s_axi_rdata,
    output logic [1:0]                     s_axi_rresp,
    output logic                           s_axi_rvalid,
    input  logic                           s_axi_rready,

    input  logic [ADDR_W-1:0]              s_axi_awaddr,
    input  logic                           s_axi_awvalid,
    output logic                           s_axi_awready,
    input  logic [DATA_W-1:0]              s_axi_wdata,
    input  logic [DATA_W/8-1:0]            s_axi_wstrb,
    input  logic                           s_axi_wvalid,
    output logic                           s_axi_wready,
    output logic [1:0]                     s_axi_bresp,
    output logic                           s_axi_bvalid,
    input  logic                           s_axi_bready,

    output logic [NUM_SLAVES*ADDR_W-1:0]   m_axi_araddr,
    output logic [NUM_SLAVES-1:0]          m_axi_arvalid,
    input  logic [NUM_SLAVES-1:0]          m_axi_arready,
    input  logic [NUM_SLAVES*DATA_W-1:0]   m_axi_rdata,
    input  logic [NUM_SLAVES*2-1:0]        m_axi_rresp,
    input  logic [NUM_SLAVES-1:0]          m_axi_rvalid,
    output logic [NUM_SLAVES-1:0]          m_axi_rready,

    output logic [NUM_SLAVES*ADDR_W-1:0]   m_axi_awaddr,
    output logic [NUM_SLAVES-1:0]          m_axi_awvalid,
    input  logic [NUM_SLAVES-1:0]          m_axi_awready,
    output logic [NUM_SLAVES*DATA_W-1:0]   m_axi_wdata,
    output logic [NUM_SLAVES*DATA_W/8-1:0] m_axi_wstrb,
    output logic [NUM_SLAVES-1:0]          m_axi_wvalid,
    input  logic [NUM_SLAVES-1:0]          m_axi_wready,
    input  logic [NUM_SLAVES*2-1:0]        m_axi_bresp,
    input  logic [NUM_SLAVES-1:0]          m_axi_bvalid,
    output logic [NUM_SLAVES-1:0]          m_axi_bready
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned SLOT_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int unsigned CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit          TO_EN  = (TIMEOUT_CYCLES != 0);
    // Counter value at which the TIMEOUT_CYCLES-th cycle in the wait states ends.
    localparam logic [CNT_W-1:0] TO_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] { R_IDLE, R_ADDR, R_DATA, R_RESP } r_state_t;
    typedef enum logic [1:0] { W_IDLE, W_FWD, W_BRESP, W_RESP } w_state_t;

    typedef struct packed {
        logic              hit;
        logic [SLOT_W-1:0] slot;
    } dec_t;

    // The subtraction carries one extra bit so "addr below BASE_ADDR" is the
    // borrow out, which also stays meaningful when BASE_ADDR is zero.
    function automatic dec_t decode(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W:0]   diff;
        logic [ADDR_W-1:0] idx;
        dec_t              d;
        diff   = {1'b0, addr} - {1'b0, BASE_ADDR};
        idx    = diff[ADDR_W-1:0] >> REGION_LOG2;
        d.hit  = !diff[ADDR_W] && (idx < ADDR_W'(NUM_SLAVES));
        d.slot = idx[SLOT_W-1:0];
        return d;
    endfunction

    function automatic logic [NUM_SLAVES-1:0] onehot(input logic [SLOT_W-1:0] s);
        return NUM_SLAVES'(1) << s;
    endfunction

    // ------------------------------------------------------------------ read
    r_state_t               r_state;
    logic [SLOT_W-1:0]      r_slot;
    logic [ADDR_W-1:0]      ar_addr;
    logic                   arready_q;
    logic [NUM_SLAVES-1:0]  m_arvalid_q;
    logic [NUM_SLAVES-1:0]  m_rready_q;
    logic                   rvalid_q;
    logic [DATA_W-1:0]      rdata_q;
    logic [1:0]             rresp_q;
    logic [CNT_W-1:0]       r_cnt;

    dec_t r_dec;
    logic ar_hs;
    logic r_hs;
    logic r_expire;

    assign r_dec    = decode(s_axi_araddr);
    // Only the selected slot's bit can be set, so OR-reducing the masked
    // vector is the handshake for that slot.
    assign ar_hs    = |(m_arvalid_q & m_axi_arready);
    assign r_hs     = |(m_rready_q & m_axi_rvalid);
    assign r_expire = TO_EN && (r_cnt == TO_LAST);

    // NOTE: every register is reset asynchronously and updated with
    // non-blocking assignments, so the FSM sees only pre-edge values and the
    // last assignment in a branch wins without creating ordering hazards.
    always_ff @(posedge s_axi_aclk or negedge s_axi_areset) begin
        if (!s_axi_areset) begin
            r_state     <= R_IDLE;
            r_slot      <= '0;
            ar_addr     <= '0;
            arready_q   <= 1'b0;
            m_arvalid_q <= '0;
            m_rready_q  <= '0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            rresp_q     <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (arready_q && s_axi_arvalid) begin
                        arready_q <= 1'b0;
                        ar_addr   <= s_axi_araddr;
                        r_slot    <= r_dec.slot;
                        r_cnt     <= '0;
                        if (r_dec.hit) begin
                            m_arvalid_q <= onehot(r_dec.slot);
                            r_state     <= R_ADDR;
                        end else begin
                            rresp_q <= RESP_DECERR;
                            rdata_q <= '0;
                            r_state <= R_RESP;
                        end
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_ADDR: begin
                    if (ar_hs) begin
                        m_arvalid_q <= '0;
                        m_rready_q  <= onehot(r_slot);
                        r_cnt       <= r_cnt + 1'b1;
                        r_state     <= R_DATA;
                    end else if (r_expire) begin
                        m_arvalid_q <= '0;
                        rresp_q     <= RESP_SLVERR;
                        rdata_q     <= '0;
                        r_state     <= R_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                R_DATA: begin
                    if (r_hs) begin
                        m_rready_q <= '0;
                        rdata_q    <= m_axi_rdata[r_slot*DATA_W +: DATA_W];
                        rresp_q    <= m_axi_rresp[r_slot*2 +: 2];
                        r_state    <= R_RESP;
                    end else if (r_expire) begin
                        m_rready_q <= '0;
                        rresp_q    <= RESP_SLVERR;
                        rdata_q    <= '0;
                        r_state    <= R_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                R_RESP: begin
                    // One registration cycle before rvalid rises; then hold
                    // rdata/rresp untouched until the upstream accepts.
                    if (!rvalid_q) begin
                        rvalid_q <= 1'b1;
                    end else if (s_axi_rready) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        r_state   <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // ----------------------------------------------------------------- write
    w_state_t               w_state;
    logic [SLOT_W-1:0]      w_slot;
    logic [ADDR_W-1:0]      aw_addr;
    logic [DATA_W-1:0]      w_data;
    logic [STRB_W-1:0]      w_strb;
    logic                   w_live;
    logic [NUM_SLAVES-1:0]  m_awvalid_q;
    logic [NUM_SLAVES-1:0]  m_wvalid_q;
    logic [NUM_SLAVES-1:0]  m_bready_q;
    logic                   bvalid_q;
    logic [1:0]             bresp_q;
    logic [CNT_W-1:0]       w_cnt;

    dec_t w_dec;
    logic w_accept;
    logic aw_hs;
    logic w_hs;
    logic aw_fin;
    logic w_fin;
    logic b_hs;
    logic w_expire;

    assign w_dec    = decode(s_axi_awaddr);
    // AW and W are taken together in one cycle. w_live is low in reset and
    // for the first cycle after it, keeping the ready outputs at 0 there.
    assign w_accept = w_live && (w_state == W_IDLE) && s_axi_awvalid && s_axi_wvalid;
    assign aw_hs    = |(m_awvalid_q & m_axi_awready);
    assign w_hs     = |(m_wvalid_q & m_axi_wready);
    // A channel is finished once its valid bit is gone or is handshaking now.
    assign aw_fin   = (m_awvalid_q == '0) || aw_hs;
    assign w_fin    = (m_wvalid_q == '0) || w_hs;
    assign b_hs     = |(m_bready_q & m_axi_bvalid);
    assign w_expire = TO_EN && (w_cnt == TO_LAST);

    always_ff @(posedge s_axi_aclk or negedge s_axi_areset) begin
        if (!s_axi_areset) begin
            w_state     <= W_IDLE;
            w_slot      <= '0;
            aw_addr     <= '0;
            w_data      <= '0;
            w_strb      <= '0;
            w_live      <= 1'b0;
            m_awvalid_q <= '0;
            m_wvalid_q  <= '0;
            m_bready_q  <= '0;
            bvalid_q    <= 1'b0;
            bresp_q     <= '0;
            w_cnt       <= '0;
        end else begin
            w_live <= 1'b1;
            case (w_state)
                W_IDLE: begin
                    if (w_accept) begin
                        aw_addr <= s_axi_awaddr;
                        w_data  <= s_axi_wdata;
                        w_strb  <= s_axi_wstrb;
                        w_slot  <= w_dec.slot;
                        w_cnt   <= '0;
                        if (w_dec.hit) begin
                            m_awvalid_q <= onehot(w_dec.slot);
                            m_wvalid_q  <= onehot(w_dec.slot);
                            w_state     <= W_FWD;
                        end else begin
                            bresp_q <= RESP_DECERR;
                            w_state <= W_RESP;
                        end
                    end
                end
                W_FWD: begin
                    if (aw_hs) m_awvalid_q <= '0;
                    if (w_hs)  m_wvalid_q  <= '0;
                    if (aw_fin && w_fin) begin
                        m_bready_q <= onehot(w_slot);
                        w_cnt      <= w_cnt + 1'b1;
                        w_state    <= W_BRESP;
                    end else if (w_expire) begin
                        m_awvalid_q <= '0;
                        m_wvalid_q  <= '0;
                        bresp_q     <= RESP_SLVERR;
                        w_state     <= W_RESP;
                    end else begin
                        w_cnt <= w_cnt + 1'b1;
                    end
                end
                W_BRESP: begin
                    if (b_hs) begin
                        m_bready_q <= '0;
                        bresp_q    <= m_axi_bresp[w_slot*2 +: 2];
                        w_state    <= W_RESP;
                    end else if (w_expire) begin
                        m_bready_q <= '0;
                        bresp_q    <= RESP_SLVERR;
                        w_state    <= W_RESP;
                    end else begin
                        w_cnt <= w_cnt + 1'b1;
                    end
                end
                W_RESP: begin
                    if (!bvalid_q) begin
                        bvalid_q <= 1'b1;
                    end else if (s_axi_bready) begin
                        bvalid_q <= 1'b0;
                        w_state  <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // --------------------------------------------------------------- outputs
    assign s_axi_arready = arready_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rvalid  = rvalid_q;

    assign s_axi_awready = w_accept;
    assign s_axi_wready  = w_accept;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_bvalid  = bvalid_q;

    assign m_axi_araddr  = {NUM_SLAVES{ar_addr}};
    assign m_axi_arvalid = m_arvalid_q;
    assign m_axi_rready  = m_rready_q;

    assign m_axi_awaddr  = {NUM_SLAVES{aw_addr}};
    assign m_axi_awvalid = m_awvalid_q;
    assign m_axi_wdata   = {NUM_SLAVES{w_data}};
    assign m_axi_wstrb   = {NUM_SLAVES{w_strb}};
    assign m_axi_wvalid  = m_wvalid_q;
    assign m_axi_bready  = m_bready_q;

endmodule

// File: tb/tb_axi4lite_interconnect_param.sv
// ---------------------------------------------------------------------------
// tb_axi4lite_interconnect_param
//
// Directed bench for axi4lite_interconnect_param with 16 ports, 32-bit
// address/data, BASE_ADDR 0, 64-byte regions and an 8-cycle timeout.
// Downstream ports are modelled as simple always-ready responders whose
// valid/resp/data vectors are set per step.
// ---------------------------------------------------------------------------
module tb_axi4lite_interconnect_param;

    localparam int N  = 16;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [AW-1:0]   s_araddr = '0;
    logic            s_arvalid = 1'b0;
    logic            s_arready;
    logic [DW-1:0]   s_rdata;
    logic [1:0]      s_rresp;
    logic            s_rvalid;
    logic            s_rready = 1'b0;
    logic [AW-1:0]   s_awaddr = '0;
    logic            s_awvalid = 1'b0;
    logic            s_awready;
    logic [DW-1:0]   s_wdata = '0;
    logic [SW-1:0]   s_wstrb = '0;
    logic            s_wvalid = 1'b0;
    logic            s_wready;
    logic [1:0]      s_bresp;
    logic            s_bvalid;
    logic            s_bready = 1'b0;

    logic [N*AW-1:0] m_araddr;
    logic [N-1:0]    m_arvalid;
    logic [N-1:0]    m_arready = '1;
    logic [N*DW-1:0] m_rdata = '0;
    logic [N*2-1:0]  m_rresp = '0;
    logic [N-1:0]    m_rvalid = '1;
    logic [N-1:0]    m_rready;
    logic [N*AW-1:0] m_awaddr;
    logic [N-1:0]    m_awvalid;
    logic [N-1:0]    m_awready = '1;
    logic [N*DW-1:0] m_wdata;
    logic [N*SW-1:0] m_wstrb;
    logic [N-1:0]    m_wvalid;
    logic [N-1:0]    m_wready = '1;
    logic [N*2-1:0]  m_bresp = '0;
    logic [N-1:0]    m_bvalid = '1;
    logic [N-1:0]    m_bready;

    axi4lite_interconnect_param #(
        .NUM_SLAVES(N), .ADDR_W(AW), .DATA_W(DW), .BASE_ADDR('0),
        .REGION_LOG2(6), .TIMEOUT_CYCLES(TO)
    ) dut (
        .s_axi_aclk(clk),         .s_axi_areset(rst_n),
        .s_axi_araddr(s_araddr),  .s_axi_arvalid(s_arvalid), .s_axi_arready(s_arready),
        .s_axi_rdata(s_rdata),    .s_axi_rresp(s_rresp),     .s_axi_rvalid(s_rvalid),
        .s_axi_rready(s_rready),
        .s_axi_awaddr(s_awaddr),  .s_axi_awvalid(s_awvalid), .s_axi_awready(s_awready),
        .s_axi_wdata(s_wdata),    .s_axi_wstrb(s_wstrb),     .s_axi_wvalid(s_wvalid),
        .s_axi_wready(s_wready),
        .s_axi_bresp(s_bresp),    .s_axi_bvalid(s_bvalid),   .s_axi_bready(s_bready),
        .m_axi_araddr(m_araddr),  .m_axi_arvalid(m_arvalid), .m_axi_arready(m_arready),
        .m_axi_rdata(m_rdata),    .m_axi_rresp(m_rresp),     .m_axi_rvalid(m_rvalid),
        .m_axi_rready(m_rready),
        .m_axi_awaddr(m_awaddr),  .m_axi_awvalid(m_awvalid), .m_axi_awready(m_awready),
        .m_axi_wdata(m_wdata),    .m_axi_wstrb(m_wstrb),     .m_axi_wvalid(m_wvalid),
        .m_axi_wready(m_wready),
        .m_axi_bresp(m_bresp),    .m_axi_bvalid(m_bvalid),   .m_axi_bready(m_bready)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a read address and return #1 after the accepting edge.
    task automatic read_accept(input logic [AW-1:0] a, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        s_araddr  = a;
        s_arvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (s_arready === 1'b1) begin
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        s_arvalid = 1'b0;
    endtask

    // Present AW+W together and return #1 after the accepting edge.
    task automatic write_accept(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                input logic [SW-1:0] s, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        s_awaddr  = a;
        s_wdata   = d;
        s_wstrb   = s;
        s_awvalid = 1'b1;
        s_wvalid  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (s_awready === 1'b1 && s_wready === 1'b1) begin
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
    endtask

    // Count rising edges until rvalid (sel_b=0) or bvalid (sel_b=1); -1 on expiry.
    task automatic wait_valid(input bit sel_b, input int max, output int n);
        n = 0;
        while (((sel_b ? s_bvalid : s_rvalid) !== 1'b1) && n < max) begin
            @(posedge clk); #1;
            n++;
        end
        if ((sel_b ? s_bvalid : s_rvalid) !== 1'b1) n = -1;
    endtask

    task automatic read_ack();
        @(negedge clk); s_rready = 1'b1;
        @(posedge clk); #1; s_rready = 1'b0;
    endtask

    task automatic write_ack();
        @(negedge clk); s_bready = 1'b1;
        @(posedge clk); #1; s_bready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of sequence");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         ok;
        int         n;
        bit         stable;
        logic [N-1:0] act;
        logic       seen;

        // Distinct data per port so a wrong slot select is visible.
        for (int i = 0; i < N; i++) m_rdata[i*DW +: DW] = 32'h1000 + i;
        m_rdata[4*DW +: DW]   = 32'd89;
        m_rdata[15*DW +: DW]  = 32'hDEAD_BEEF;
        m_bresp[11*2 +: 2]    = 2'b01;

        // ---- reset state
        #12;
        check("rst_arready", s_arready, 1'b0);
        check("rst_awready", s_awready, 1'b0);
        check("rst_rvalid",  s_rvalid, 1'b0);
        check("rst_bvalid",  s_bvalid, 1'b0);
        check("rst_m_valid", {m_arvalid, m_awvalid, m_wvalid}, 48'h0);
        check("rst_m_ready", {m_rready, m_bready}, 32'h0);
        check("rst_araddr0", m_araddr[0 +: AW], 32'h0);
        @(negedge clk); rst_n = 1'b1;

        // ---- read 300 -> slot 4, zero-wait downstream, 3-edge latency
        read_accept(32'd300, ok);
        check("rd1_accept", ok, 1'b1);
        check("rd1_arvalid", m_arvalid, 16'h0010);
        check("rd1_araddr4", m_araddr[4*AW +: AW], 32'd300);
        wait_valid(1'b0, 20, n);
        check("rd1_latency", n, 3);
        check("rd1_rdata", s_rdata, 32'd89);
        check("rd1_rresp", s_rresp, 2'b00);
        read_ack();
        check("rd1_rvalid_drop", s_rvalid, 1'b0);

        // ---- AW without W must not be accepted
        @(negedge clk); s_awaddr = 32'd710; s_awvalid = 1'b1; s_wvalid = 1'b0;
        #1;
        check("aw_only_awready", s_awready, 1'b0);
        @(posedge clk); #1;
        check("aw_only_no_fwd", m_awvalid, 16'h0);
        s_awvalid = 1'b0;

        // ---- write 710 -> slot 11, downstream EXOKAY passes through
        write_accept(32'd710, 32'd11, 4'h3, ok);
        check("wr1_accept", ok, 1'b1);
        check("wr1_awvalid", m_awvalid, 16'h0800);
        check("wr1_wvalid", m_wvalid, 16'h0800);
        check("wr1_awaddr11", m_awaddr[11*AW +: AW], 32'd710);
        check("wr1_wdata11", m_wdata[11*DW +: DW], 32'd11);
        check("wr1_wstrb11", m_wstrb[11*SW +: SW], 4'h3);
        wait_valid(1'b1, 20, n);
        check("wr1_latency", n, 3);
        check("wr1_bresp", s_bresp, 2'b01);
        write_ack();
        check("wr1_bvalid_drop", s_bvalid, 1'b0);

        // ---- read 1100 -> slot 17, unmapped: DECERR, no downstream activity
        read_accept(32'd1100, ok);
        check("rd_unmap_accept", ok, 1'b1);
        act = m_arvalid | m_rready;
        n = 0;
        while (s_rvalid !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            act |= m_arvalid | m_rready;
            n++;
        end
        check("rd_unmap_no_m", act, 16'h0);
        check("rd_unmap_rvalid", s_rvalid, 1'b1);
        check("rd_unmap_rresp", s_rresp, 2'b11);
        check("rd_unmap_rdata", s_rdata, 32'h0);
        read_ack();

        // ---- read slot 15 with no downstream rvalid: SLVERR after timeout
        m_rvalid = '0;
        read_accept(32'd960, ok);
        check("rd_to_arvalid", m_arvalid, 16'h8000);
        @(posedge clk); #1;
        check("rd_to_rready", m_rready, 16'h8000);
        wait_valid(1'b0, 20, n);
        n = n + 1;
        check("rd_to_window", (n >= TO) && (n <= TO + 2), 1'b1);
        check("rd_to_rresp", s_rresp, 2'b10);
        check("rd_to_rdata", s_rdata, 32'h0);
        check("rd_to_rready_drop", m_rready, 16'h0);
        read_ack();
        m_rvalid = '1;

        // ---- response held under backpressure while a write runs
        read_accept(32'd300, ok);
        wait_valid(1'b0, 20, n);
        check("conc_rd_up", s_rvalid, 1'b1);
        @(negedge clk);
        s_awaddr = 32'd64; s_wdata = 32'h55; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                check("conc_wr_awvalid", m_awvalid, 16'h0002);
                s_awvalid = 1'b0; s_wvalid = 1'b0;
            end
            if (s_rvalid !== 1'b1 || s_rdata !== 32'd89) stable = 1'b0;
        end
        check("conc_rd_stable", stable, 1'b1);
        check("conc_wr_bvalid", s_bvalid, 1'b1);
        check("conc_wr_bresp", s_bresp, 2'b00);
        read_ack();
        write_ack();

        // ---- reset while waiting in W_BRESP
        m_bvalid = '0;
        write_accept(32'd128, 32'h77, 4'h1, ok);
        @(posedge clk); #1;
        check("rst_wb_bready", m_bready, 16'h0004);
        rst_n = 1'b0;
        #1;
        check("rst_wb_bready0", m_bready, 16'h0);
        check("rst_wb_wdata0", m_wdata[0 +: DW], 32'h0);
        check("rst_wb_outs", {s_bvalid, s_arready, s_awready, s_rvalid}, 4'h0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        m_bvalid = '1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            seen |= s_bvalid;
        end
        check("rst_wb_no_bvalid", seen, 1'b0);
        write_accept(32'd128, 32'h78, 4'h1, ok);
        check("post_rst_accept", ok, 1'b1);
        wait_valid(1'b1, 20, n);
        check("post_rst_latency", n, 3);
        check("post_rst_bresp", s_bresp, 2'b00);
        write_ack();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
